// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_if
//  Purpose  : Bundles the ICache, LSB and memory-controller handshake/bus
//             signals seen by mem_arbiter. The slave modport is the arbiter's
//             view; the master modport is the view of the surrounding logic.
//  Revision : 1.0  initial release
// ============================================================================
interface mem_arbiter_if;
    // ICache side
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_done;
    logic [31:0] ic_data;
    // LSB side
    logic        lsb_req;
    logic [31:0] lsb_addr;
    logic [31:0] lsb_wdata;
    logic [2:0]  lsb_type;
    logic        lsb_done;
    logic [31:0] lsb_rdata;
    // Memory controller side
    logic        mc_flag_ic;
    logic [31:0] mc_addr_ic;
    logic        mc_flag_lsb;
    logic [31:0] mc_addr_lsb;
    logic [31:0] mc_wdata_lsb;
    logic [2:0]  mc_type_lsb;
    logic        mc_done_ic;
    logic [31:0] mc_data_ic;
    logic        mc_done_lsb;
    logic [31:0] mc_data_lsb;

    modport slave (
        input  ic_req, ic_addr, lsb_req, lsb_addr, lsb_wdata, lsb_type,
               mc_done_ic, mc_data_ic, mc_done_lsb, mc_data_lsb,
        output ic_done, ic_data, lsb_done, lsb_rdata,
               mc_flag_ic, mc_addr_ic, mc_flag_lsb, mc_addr_lsb,
               mc_wdata_lsb, mc_type_lsb
    );

    modport master (
        output ic_req, ic_addr, lsb_req, lsb_addr, lsb_wdata, lsb_type,
               mc_done_ic, mc_data_ic, mc_done_lsb, mc_data_lsb,
        input  ic_done, ic_data, lsb_done, lsb_rdata,
               mc_flag_ic, mc_addr_ic, mc_flag_lsb, mc_addr_lsb,
               mc_wdata_lsb, mc_type_lsb
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Shares one byte-serial memory controller between ICache fetches
//             and LSB loads/stores. LSB has priority, bounded by a starvation
//             counter that forces an IC grant after STARVE_MAX LSB wins.
//             Each access is followed by one idle turnaround cycle. A flush
//             (jp_wrong) aborts fetches and loads but never an in-flight store.
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rdy_i,
    input  logic          jp_wrong_i,
    mem_arbiter_if.slave  bus
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_IC_BUSY  = 2'd1;
    localparam logic [1:0] c_LSB_BUSY = 2'd2;
    localparam logic [1:0] c_TURN     = 2'd3;

    localparam logic [CNT_W-1:0] c_STARVE_MAX = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] c_CNT_ONE    = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    logic             ic_done_q;
    logic [31:0]      ic_data_q;
    logic             lsb_done_q;
    logic [31:0]      lsb_rdata_q;
    logic [31:0]      mc_addr_ic_q;
    logic [31:0]      mc_addr_lsb_q;
    logic [31:0]      mc_wdata_lsb_q;
    logic [2:0]       mc_type_lsb_q;

    logic             grant_ic;
    logic             grant_lsb;
    logic             finish_ic;
    logic             finish_lsb;
    logic             lsb_is_store;
    logic             mc_flag_ic;
    logic             mc_flag_lsb;

    // The latched access type decides whether a flush may abort the access.
    assign lsb_is_store = mc_type_lsb_q[2] && (mc_type_lsb_q[1:0] != 2'b00);

    // State register and starvation counter; everything freezes while rdy is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= c_IDLE;
            starve_cnt_q <= '0;
        end else if (rdy_i) begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Next-state, grant and completion decisions.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        grant_ic     = 1'b0;
        grant_lsb    = 1'b0;
        finish_ic    = 1'b0;
        finish_lsb   = 1'b0;
        case (state_q)
            c_IDLE: begin
                if (!jp_wrong_i) begin
                    if (bus.lsb_req && !(bus.ic_req && starve_cnt_q == c_STARVE_MAX)) begin
                        grant_lsb = 1'b1;
                        state_d   = c_LSB_BUSY;
                    end else if (bus.ic_req) begin
                        grant_ic  = 1'b1;
                        state_d   = c_IC_BUSY;
                    end
                end
            end
            c_IC_BUSY: begin
                // A flush wins over a coincident completion: the fetch is discarded.
                if (jp_wrong_i) begin
                    state_d = c_TURN;
                end else if (bus.mc_done_ic) begin
                    finish_ic = 1'b1;
                    state_d   = c_TURN;
                end
            end
            c_LSB_BUSY: begin
                // Stores already reaching memory cannot be recalled, so they ignore the flush.
                if (jp_wrong_i && !lsb_is_store) begin
                    state_d = c_TURN;
                end else if (bus.mc_done_lsb) begin
                    finish_lsb = 1'b1;
                    state_d    = c_TURN;
                end
            end
            c_TURN: begin
                state_d = c_IDLE;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase

        // Count consecutive LSB wins over a waiting fetch; any flush or an
        // absent fetch request resets the fairness window.
        if (jp_wrong_i || !bus.ic_req) begin
            starve_cnt_d = '0;
        end else if (grant_ic) begin
            starve_cnt_d = '0;
        end else if (grant_lsb && starve_cnt_q != c_STARVE_MAX) begin
            starve_cnt_d = starve_cnt_q + c_CNT_ONE;
        end
    end

    // Request flags are decoded from state so they can never both be high.
    always_comb begin
        mc_flag_ic  = (state_q == c_IC_BUSY);
        mc_flag_lsb = (state_q == c_LSB_BUSY);
    end

    // Request latches and registered completion pulses toward the requesters.
    always_ff @(posedge clk) begin
        if (rst) begin
            ic_done_q      <= 1'b0;
            ic_data_q      <= '0;
            lsb_done_q     <= 1'b0;
            lsb_rdata_q    <= '0;
            mc_addr_ic_q   <= '0;
            mc_addr_lsb_q  <= '0;
            mc_wdata_lsb_q <= '0;
            mc_type_lsb_q  <= '0;
        end else if (rdy_i) begin
            ic_done_q  <= finish_ic;
            lsb_done_q <= finish_lsb;
            if (finish_ic) begin
                ic_data_q <= bus.mc_data_ic;
            end
            if (finish_lsb) begin
                lsb_rdata_q <= lsb_is_store ? 32'd0 : bus.mc_data_lsb;
            end
            if (grant_ic) begin
                mc_addr_ic_q <= bus.ic_addr;
            end
            if (grant_lsb) begin
                mc_addr_lsb_q  <= bus.lsb_addr;
                mc_wdata_lsb_q <= bus.lsb_wdata;
                mc_type_lsb_q  <= bus.lsb_type;
            end
        end
    end

    assign bus.ic_done      = ic_done_q;
    assign bus.ic_data      = ic_data_q;
    assign bus.lsb_done     = lsb_done_q;
    assign bus.lsb_rdata    = lsb_rdata_q;
    assign bus.mc_flag_ic   = mc_flag_ic;
    assign bus.mc_addr_ic   = mc_addr_ic_q;
    assign bus.mc_flag_lsb  = mc_flag_lsb;
    assign bus.mc_addr_lsb  = mc_addr_lsb_q;
    assign bus.mc_wdata_lsb = mc_wdata_lsb_q;
    assign bus.mc_type_lsb  = mc_type_lsb_q;

endmodule
`default_nettype wire
